// File: rtl/pwm_pkg.sv
// Constants and state encoding shared by the duty ramp sequencer and the PWM generator.
package pwm_pkg;

    localparam int PERIOD = 32;
    localparam int DUTY_W = 6;
    localparam int RATE_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } ramp_state_t;

endpackage

// File: rtl/pwm_tick_div.sv
// Step-rate divider: counts qualified PWM period ticks and flags the last tick of a step interval.
module pwm_tick_div #(
    parameter int RATE_W = pwm_pkg::RATE_W
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              clr,
    input  logic              adv,
    input  logic [RATE_W-1:0] rate,
    output logic              tc
);

    logic [RATE_W-1:0] div_cnt_q;
    logic [RATE_W-1:0] div_cnt_d;

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (clr) begin
            div_cnt_d = '0;
        end else if (adv) begin
            div_cnt_d = div_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    // rate is never 0 while ramping, so the wrap of rate-1 is never observed.
    assign tc = (div_cnt_q == rate - 1'b1);

endmodule

// File: rtl/pwm_duty_ramp.sv
// Soft-start duty sequencer: one-deep target slot, IDLE/RAMP FSM and the registered duty output.
module pwm_duty_ramp #(
    parameter int PERIOD = pwm_pkg::PERIOD,
    parameter int DUTY_W = pwm_pkg::DUTY_W,
    parameter int RATE_W = pwm_pkg::RATE_W
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic [DUTY_W-1:0] target_in,
    input  logic [RATE_W-1:0] rate_in,
    input  logic              target_valid,
    output logic              target_ready,
    input  logic              period_tick,
    input  logic              enable,
    output logic [DUTY_W-1:0] duty_out,
    output logic              at_target,
    output logic              busy,
    output logic              ramp_done
);

    import pwm_pkg::*;

    ramp_state_t       state_q, state_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [DUTY_W-1:0] cur_tgt_q, cur_tgt_d;
    logic [RATE_W-1:0] rate_q, rate_d;
    logic [DUTY_W-1:0] pend_tgt_q, pend_tgt_d;
    logic [RATE_W-1:0] pend_rate_q, pend_rate_d;
    logic              pend_valid_q, pend_valid_d;
    logic              done_q, done_d;

    logic              accept;
    logic              qual_tick;
    logic              consume;
    logic              div_clr;
    logic              div_adv;
    logic              div_tc;
    logic [DUTY_W-1:0] tgt_clamped;
    logic [DUTY_W-1:0] duty_step;

    assign accept      = target_valid & ~pend_valid_q;
    assign qual_tick   = period_tick & enable;
    // pend_valid is registered, so a tick on the acceptance edge cannot consume.
    assign consume     = qual_tick & pend_valid_q;
    assign tgt_clamped = (target_in > DUTY_W'(PERIOD)) ? DUTY_W'(PERIOD) : target_in;
    assign duty_step   = (cur_tgt_q > duty_q) ? duty_q + 1'b1 : duty_q - 1'b1;

    pwm_tick_div #(.RATE_W(RATE_W)) u_div (
        .clk_in (clk_in),
        .rst    (rst),
        .clr    (div_clr),
        .adv    (div_adv),
        .rate   (rate_q),
        .tc     (div_tc)
    );

    always_comb begin
        state_d      = state_q;
        duty_d       = duty_q;
        cur_tgt_d    = cur_tgt_q;
        rate_d       = rate_q;
        pend_tgt_d   = pend_tgt_q;
        pend_rate_d  = pend_rate_q;
        pend_valid_d = pend_valid_q;
        done_d       = 1'b0;
        div_clr      = 1'b0;
        div_adv      = 1'b0;

        if (accept) begin
            pend_valid_d = 1'b1;
            pend_tgt_d   = tgt_clamped;
            pend_rate_d  = rate_in;
        end

        if (consume) begin
            pend_valid_d = 1'b0;
            cur_tgt_d    = pend_tgt_q;
            rate_d       = pend_rate_q;
            div_clr      = 1'b1;
            if ((pend_rate_q == '0) || (duty_q == pend_tgt_q)) begin
                duty_d  = pend_tgt_q;
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                state_d = RAMP;
            end
        end else if (qual_tick && (state_q == RAMP)) begin
            if (div_tc) begin
                div_clr = 1'b1;
                duty_d  = duty_step;
                if (duty_step == cur_tgt_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end else begin
                div_adv = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            duty_q       <= '0;
            cur_tgt_q    <= '0;
            rate_q       <= '0;
            pend_tgt_q   <= '0;
            pend_rate_q  <= '0;
            pend_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            duty_q       <= duty_d;
            cur_tgt_q    <= cur_tgt_d;
            rate_q       <= rate_d;
            pend_tgt_q   <= pend_tgt_d;
            pend_rate_q  <= pend_rate_d;
            pend_valid_q <= pend_valid_d;
            done_q       <= done_d;
        end
    end

    assign duty_out     = duty_q;
    assign ramp_done    = done_q;
    assign target_ready = ~pend_valid_q;
    assign at_target    = (state_q == IDLE) && ~pend_valid_q;
    assign busy         = ~at_target;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Scoreboard bench for pwm_duty_ramp: each issued tick queues its expected duty/done, a monitor checks them.
module tb_pwm_duty_ramp;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] target_in = '0;
    logic [7:0] rate_in = '0;
    logic       target_valid = 1'b0;
    logic       target_ready;
    logic       period_tick = 1'b0;
    logic       enable = 1'b1;
    logic [5:0] duty_out;
    logic       at_target;
    logic       busy;
    logic       ramp_done;

    typedef struct packed {
        logic [5:0] duty;
        logic       done;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;
    int   done_seen = 0;

    pwm_duty_ramp dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .target_in    (target_in),
        .rate_in      (rate_in),
        .target_valid (target_valid),
        .target_ready (target_ready),
        .period_tick  (period_tick),
        .enable       (enable),
        .duty_out     (duty_out),
        .at_target    (at_target),
        .busy         (busy),
        .ramp_done    (ramp_done)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every sampled tick edge is a DUT output event.
    always @(posedge clk_in) begin
        if (period_tick && !rst) begin
            #1;
            if (exp_q.size() == 0) begin
                check("tick_without_expectation", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("tick_duty", int'(duty_out), int'(mon_e.duty));
                check("tick_done", int'(ramp_done), int'(mon_e.done));
            end
        end
    end

    always @(negedge clk_in) begin
        if (ramp_done) done_seen++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        rst = 1'b1;
        period_tick = 1'b0;
        target_valid = 1'b0;
        enable = 1'b1;
        repeat (2) @(negedge clk_in);
        rst = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic send(input int t, input int r, input bit with_tick, input int exp_duty);
        check("ready_before_send", int'(target_ready), 1);
        target_in = 6'(t);
        rate_in = 8'(r);
        target_valid = 1'b1;
        if (with_tick) begin
            exp_q.push_back('{duty: 6'(exp_duty), done: 1'b0});
            period_tick = 1'b1;
        end
        @(negedge clk_in);
        target_valid = 1'b0;
        period_tick = 1'b0;
        check("ready_after_accept", int'(target_ready), 0);
    endtask

    task automatic tick(input int d, input bit done, input bit en);
        exp_q.push_back('{duty: 6'(d), done: done});
        enable = en;
        period_tick = 1'b1;
        @(negedge clk_in);
        period_tick = 1'b0;
        @(negedge clk_in);
    endtask

    initial begin
        do_reset();
        check("reset_duty", int'(duty_out), 0);
        check("reset_ready", int'(target_ready), 1);
        check("reset_at_target", int'(at_target), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_ramp_done", int'(ramp_done), 0);

        // Rate 0 jump; a tick on the acceptance edge must not consume.
        send(20, 0, 1'b1, 0);
        check("pending_busy", int'(busy), 1);
        check("pending_at_target", int'(at_target), 0);
        tick(20, 1'b1, 1'b1);
        check("jump_at_target", int'(at_target), 1);
        check("jump_ready", int'(target_ready), 1);

        // 0 -> 4 at rate 2
        do_reset();
        send(4, 2, 1'b0, 0);
        tick(0, 1'b0, 1'b1);
        tick(0, 1'b0, 1'b1); tick(1, 1'b0, 1'b1);
        tick(1, 1'b0, 1'b1); tick(2, 1'b0, 1'b1);
        tick(2, 1'b0, 1'b1); tick(3, 1'b0, 1'b1);
        tick(3, 1'b0, 1'b1); tick(4, 1'b1, 1'b1);
        check("ramp4_at_target", int'(at_target), 1);

        // Clamp 50 -> 32, then down to 30 at rate 1
        send(50, 0, 1'b0, 0);
        tick(32, 1'b1, 1'b1);
        send(30, 1, 1'b0, 0);
        tick(32, 1'b0, 1'b1);
        tick(31, 1'b0, 1'b1);
        tick(30, 1'b1, 1'b1);

        // Retarget to 5 at duty 10 during a 0 -> 20 ramp
        do_reset();
        send(20, 1, 1'b0, 0);
        tick(0, 1'b0, 1'b1);
        for (int k = 1; k <= 10; k++) tick(k, 1'b0, 1'b1);
        send(5, 1, 1'b0, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_in);
            check("retarget_ready_low", int'(target_ready), 0);
        end
        tick(10, 1'b0, 1'b1);
        check("retarget_ready_after_consume", int'(target_ready), 1);
        for (int k = 9; k >= 5; k--) tick(k, (k == 5), 1'b1);

        // Freeze for 10 ticks mid-ramp 0 -> 8 at rate 3
        do_reset();
        send(8, 3, 1'b0, 0);
        tick(0, 1'b0, 1'b1);
        tick(0, 1'b0, 1'b1); tick(0, 1'b0, 1'b1);
        tick(1, 1'b0, 1'b1); tick(1, 1'b0, 1'b1);
        for (int k = 0; k < 10; k++) tick(1, 1'b0, 1'b0);
        check("frozen_busy", int'(busy), 1);
        tick(1, 1'b0, 1'b1);
        tick(2, 1'b0, 1'b1);
        for (int k = 3; k <= 8; k++) begin
            tick(k - 1, 1'b0, 1'b1);
            tick(k - 1, 1'b0, 1'b1);
            tick(k, (k == 8), 1'b1);
        end

        // Asynchronous reset at duty 12 with a pending target
        do_reset();
        send(20, 1, 1'b0, 0);
        tick(0, 1'b0, 1'b1);
        for (int k = 1; k <= 12; k++) tick(k, 1'b0, 1'b1);
        send(3, 0, 1'b0, 0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_duty", int'(duty_out), 0);
        check("async_rst_ready", int'(target_ready), 1);
        check("async_rst_ramp_done", int'(ramp_done), 0);
        check("async_rst_at_target", int'(at_target), 1);
        @(negedge clk_in);
        rst = 1'b0;
        @(negedge clk_in);
        tick(0, 1'b0, 1'b1);
        check("discarded_pending_at_target", int'(at_target), 1);

        repeat (3) @(negedge clk_in);
        check("scoreboard_drained", exp_q.size(), 0);
        check("ramp_done_pulses", done_seen, 6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pwm_duty_ramp.md
# pwm_duty_ramp

Soft-start duty-cycle sequencer sitting directly upstream of the 32-step PWM generator. It accepts a target duty over a valid/ready handshake and slews its registered duty output toward that target one count at a time, at a programmable number of PWM periods per step. Duty changes occur only on PWM period boundaries, so the downstream comparator never sees a mid-period duty change.

## Interface
Parameters:
- PERIOD, 32: PWM counts per period; maximum meaningful duty.
- DUTY_W, 6: duty width; must hold 0..PERIOD.
- RATE_W, 8: width of the step-rate field.

Ports (reset rst, asynchronous, active-high; clock clk_in):
- clk_in  in  1  clock
- rst  in  1  asynchronous active-high reset
- target_in  in  DUTY_W  requested duty
- rate_in  in  RATE_W  PWM periods per ±1 step; 0 = jump
- target_valid  in  1  target_in/rate_in valid
- target_ready  out  1  pending slot free
- period_tick  in  1  one-cycle pulse at PWM counter wrap
- enable  in  1  0 freezes ramp progress
- duty_out  out  DUTY_W  duty to the PWM generator, registered
- at_target  out  1  IDLE and no pending target
- busy  out  1  equals !at_target
- ramp_done  out  1  one-cycle pulse when a consumed target is reached

## Operation
- Pending slot: target accepted on the clk_in edge where target_valid & target_ready. At acceptance, target_in is clamped to PERIOD, and target and rate are stored in pend_tgt/pend_rate with pend_valid=1. target_ready = !pend_valid.
- States: IDLE (duty_out == cur_tgt) and RAMP (stepping).
- Consumption: on the first period_tick edge strictly after the acceptance edge, with enable=1:
  - cur_tgt <= pend_tgt, rate_q <= pend_rate, pend_valid <= 0, div_cnt <= 0.
  - If rate 0 or duty_out == pend_tgt: duty_out <= pend_tgt, state IDLE, ramp_done pulses.
  - Else: state RAMP, with no step taken on this tick.
- RAMP, on each period_tick with enable=1 and no consumption:
  - If div_cnt == rate_q-1: duty_out moves ±1 toward cur_tgt and div_cnt <= 0.
  - Otherwise div_cnt increments.
  - If the step lands on cur_tgt: state IDLE and ramp_done pulses.
- Retarget: a target accepted during RAMP is consumed at the next qualifying tick. The ramp restarts from the current duty_out with the new rate. Consumption has priority over a step on the same tick.
- enable=0: ticks are ignored. duty_out, div_cnt, state and pend are held. The handshake still accepts into a free slot.
- Arithmetic: unsigned. duty_out is always in 0..PERIOD and never overshoots. div_cnt is RATE_W bits.

## Timing
- Reset values: duty_out=0, cur_tgt=0, state IDLE, pend_valid=0, target_ready=1, at_target=1, busy=0, ramp_done=0, div_cnt=0.
- Reset mid-ramp forces all of the above immediately. A pending target is discarded.
- duty_out changes only on an edge where period_tick=1 is sampled. It is stable throughout the following PWM period.
- ramp_done is registered: high for exactly one cycle following the completing tick edge.
- Ramp duration for a change of N counts at rate R≥1: one consumption tick, then N·R further ticks.
- Accept/consume latency: at least one cycle. A tick in the same cycle as the handshake does not consume.
- at_target/busy are combinational from state and pend_valid.

## Structure
- Shared package pwm_pkg:
  - PERIOD, DUTY_W, RATE_W constants.
  - State enum {IDLE, RAMP}.
  - Used by both this block and the PWM generator.
- Sub-module pwm_tick_div: period_tick-qualified divider holding div_cnt, with clear, enable and terminal-count outputs.
- The top level holds the handshake slot, FSM and duty register.

## Test plan
- Reset release, then target 20 with rate 0: duty_out=20 after the first tick following acceptance; ramp_done pulses once; at_target=1.
- From duty 0, target 4 with rate 2: duty_out=0,1,1,2,2,3,3,4 on successive ticks after consumption; ramp_done once, 8 ticks after consumption.
- target_in=50: clamped, final duty_out=32. Then target 30 with rate 1: decrements of 1 per tick to 30.
- Ramp 0→20 at rate 1, new target 5 accepted at duty 10: no step on the consumption tick; then 9,8,…,5. target_ready stays low from the second accept until consumption.
- enable=0 mid-ramp for 10 ticks: duty_out and div_cnt held; resumes exactly where it stopped.
- Assert rst at duty 12 mid-ramp with a pending target: duty_out=0, target_ready=1, ramp_done=0 immediately; pending target discarded.
